// File: rtl/vme_afsm_pkg.sv
// vme_afsm_pkg: watchdog states and signal indices shared by the VME adapter and controller bench
package vme_afsm_pkg;
  typedef enum logic [1:0] {WD_IDLE, WD_WAIT_RISE, WD_WAIT_FALL} wd_state_t;
  localparam int IDX_DSR    = 0;
  localparam int IDX_DSW    = 1;
  localparam int IDX_LDTACK = 2;
  localparam int IDX_LDS    = 0;
  localparam int IDX_D      = 1;
  localparam int IDX_DTACK  = 2;
endpackage

// File: rtl/vme_edge_sync.sv
// vme_edge_sync: synchronises one async level and emits registered rise/fall pulses
module vme_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic a,
  input  logic mask,
  output logic plus,
  output logic minus
);
  logic [SYNC_STAGES-1:0] sync;
  logic s, prev;
  assign s = sync[SYNC_STAGES-1];
  always_ff @(posedge clk) begin
    if (reset) begin
      sync  <= '0;
      prev  <= 1'b0;
      plus  <= 1'b0;
      minus <= 1'b0;
    end else begin
      sync  <= {sync[SYNC_STAGES-2:0], a};
      prev  <= s;
      plus  <= s & ~prev & ~mask;
      minus <= ~s & prev & ~mask;
    end
  end
endmodule

// File: rtl/vme_event_adapter.sv
// vme_event_adapter: level/event boundary between VME pins and the event-driven controller
module vme_event_adapter
  import vme_afsm_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic dsr,
  input  logic dsw,
  input  logic ldtack,
  output logic dsr_PLUS,
  output logic dsr_MINUS,
  output logic dsw_PLUS,
  output logic dsw_MINUS,
  output logic ldtack_PLUS,
  output logic ldtack_MINUS,
  input  logic lds_PLUS,
  input  logic lds_MINUS,
  input  logic d_PLUS,
  input  logic d_MINUS,
  input  logic dtack_PLUS,
  input  logic dtack_MINUS,
  output logic lds,
  output logic d,
  output logic dtack,
  input  logic err_clr,
  output logic err_protocol,
  output logic err_timeout
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam int MW = $clog2(SYNC_STAGES + 2);
  logic [MW-1:0] mask_cnt;
  logic mask;
  assign mask = mask_cnt != '0;
  always_ff @(posedge clk) begin
    if (reset) mask_cnt <= MW'(SYNC_STAGES + 1);
    else if (mask) mask_cnt <= mask_cnt - 1'b1;
  end
  vme_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_dsr (.clk(clk), .reset(reset), .a(dsr), .mask(mask), .plus(dsr_PLUS), .minus(dsr_MINUS));
  vme_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_dsw (.clk(clk), .reset(reset), .a(dsw), .mask(mask), .plus(dsw_PLUS), .minus(dsw_MINUS));
  vme_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_ldtack (.clk(clk), .reset(reset), .a(ldtack), .mask(mask), .plus(ldtack_PLUS), .minus(ldtack_MINUS));
  logic [2:0] lvl, lvl_n, p, m, viol;
  assign p[IDX_LDS]   = lds_PLUS;
  assign p[IDX_D]     = d_PLUS;
  assign p[IDX_DTACK] = dtack_PLUS;
  assign m[IDX_LDS]   = lds_MINUS;
  assign m[IDX_D]     = d_MINUS;
  assign m[IDX_DTACK] = dtack_MINUS;
  assign lds   = lvl[IDX_LDS];
  assign d     = lvl[IDX_D];
  assign dtack = lvl[IDX_DTACK];
  // An illegal or conflicting event leaves the level untouched
  always_comb begin
    viol  = (p & m) | (p & lvl) | (m & ~lvl);
    lvl_n = (lvl | (p & ~viol)) & ~(m & ~viol);
  end
  wd_state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic acc_rise, acc_fall, to_hit, hit;
  assign acc_rise = p[IDX_LDS] & ~viol[IDX_LDS];
  assign acc_fall = m[IDX_LDS] & ~viol[IDX_LDS];
  assign hit = state == WD_WAIT_RISE ? ldtack_PLUS : ldtack_MINUS;
  // A new lds event retargets; otherwise the expected ldtack event beats an expiring counter
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    to_hit  = 1'b0;
    if (acc_rise || acc_fall) begin
      state_n = acc_rise ? WD_WAIT_RISE : WD_WAIT_FALL;
      cnt_n   = CW'(TIMEOUT);
    end else if (state != WD_IDLE) begin
      state_n = (hit || cnt == '0) ? WD_IDLE : state;
      to_hit  = !hit && cnt == '0;
      cnt_n   = (hit || cnt == '0) ? cnt : cnt - 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= WD_IDLE;
      cnt          <= '0;
      lvl          <= '0;
      err_protocol <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      lvl          <= lvl_n;
      err_protocol <= (|viol) | (err_protocol & ~err_clr);
      err_timeout  <= to_hit | (err_timeout & ~err_clr);
    end
  end
endmodule

// File: tb/tb_vme_event_adapter.sv
// tb_vme_event_adapter: scoreboard bench with cycle-stamped expectations checked by a monitor
module tb_vme_event_adapter;
  import vme_afsm_pkg::*;
  localparam int TO = 15;
  localparam int DSR_P = 0, DSR_M = 1, DSW_P = 2, DSW_M = 3, LDT_P = 4, LDT_M = 5;
  localparam int LDS = 6, DL = 7, DTK = 8, ERRP = 9, ERRT = 10, IDLE = 11;
  localparam logic [5:0] E_LDS_P = 6'b000001, E_LDS_M = 6'b000010, E_D_P = 6'b000100;
  localparam logic [5:0] E_D_M = 6'b001000, E_DT_P = 6'b010000, E_DT_M = 6'b100000;
  logic clk = 0, reset = 1, dsr = 0, dsw = 0, ldtack = 0, err_clr = 0;
  logic [5:0] ev = '0;
  logic dsr_PLUS, dsr_MINUS, dsw_PLUS, dsw_MINUS, ldtack_PLUS, ldtack_MINUS;
  logic lds, d, dtack, err_protocol, err_timeout;
  logic [11:0] obs;
  int cyc = 0, n_cmp = 0, n_bad = 0;
  typedef struct {int cyc; int sig; logic val;} exp_t;
  exp_t q[$];
  string names [12] = '{"dsr_PLUS", "dsr_MINUS", "dsw_PLUS", "dsw_MINUS", "ldtack_PLUS", "ldtack_MINUS",
                        "lds", "d", "dtack", "err_protocol", "err_timeout", "wd_idle"};
  vme_event_adapter #(.SYNC_STAGES(2), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .dsr(dsr), .dsw(dsw), .ldtack(ldtack),
    .dsr_PLUS(dsr_PLUS), .dsr_MINUS(dsr_MINUS), .dsw_PLUS(dsw_PLUS), .dsw_MINUS(dsw_MINUS),
    .ldtack_PLUS(ldtack_PLUS), .ldtack_MINUS(ldtack_MINUS),
    .lds_PLUS(ev[0]), .lds_MINUS(ev[1]), .d_PLUS(ev[2]), .d_MINUS(ev[3]),
    .dtack_PLUS(ev[4]), .dtack_MINUS(ev[5]),
    .lds(lds), .d(d), .dtack(dtack), .err_clr(err_clr),
    .err_protocol(err_protocol), .err_timeout(err_timeout));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign obs = {dut.state == WD_IDLE, err_timeout, err_protocol, dtack, d, lds,
                ldtack_MINUS, ldtack_PLUS, dsw_MINUS, dsw_PLUS, dsr_MINUS, dsr_PLUS};
  always @(negedge clk) begin
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].cyc == cyc) begin
        n_cmp++;
        if (obs[q[i].sig] !== q[i].val) begin
          n_bad++;
          $display("FAIL %s cyc=%0d actual=%b required=%b", names[q[i].sig], cyc, obs[q[i].sig], q[i].val);
        end
        q.delete(i);
      end
    end
  end
  task automatic expect_at(input int dly, input int sig, input logic val);
    q.push_back('{cyc + dly, sig, val});
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic fire(input logic [5:0] v);
    ev = v;
    step(1);
    ev = '0;
  endtask
  task automatic pulse_clr();
    err_clr = 1;
    step(1);
    err_clr = 0;
  endtask
  initial begin
    dsr = 1;
    step(3);
    expect_at(0, LDS, 0); expect_at(0, DL, 0); expect_at(0, DTK, 0);
    expect_at(0, ERRP, 0); expect_at(0, ERRT, 0); expect_at(0, IDLE, 1); expect_at(0, DSR_P, 0);
    reset = 0;
    for (int i = 1; i <= 20; i++) expect_at(i, DSR_P, 0);
    step(20);
    dsr = 0;
    expect_at(1, DSR_M, 0); expect_at(2, DSR_M, 0); expect_at(3, DSR_M, 1);
    expect_at(4, DSR_M, 0); expect_at(5, DSR_M, 0); expect_at(3, DSR_P, 0);
    step(6);
    dsw = 1;
    expect_at(3, DSW_P, 1); expect_at(4, DSW_P, 0);
    step(4);
    fire(E_LDS_P);
    expect_at(0, LDS, 1); expect_at(0, IDLE, 0);
    step(9);
    ldtack = 1;
    expect_at(3, LDT_P, 1); expect_at(4, LDT_P, 0); expect_at(4, IDLE, 1); expect_at(3, IDLE, 0);
    for (int i = 7; i <= 9; i++) begin expect_at(i, ERRT, 0); expect_at(i, ERRP, 0); expect_at(i, LDS, 1); end
    step(TO);
    fire(E_LDS_M);
    expect_at(0, LDS, 0); expect_at(0, IDLE, 0);
    ldtack = 0; dsw = 0;
    expect_at(3, LDT_M, 1); expect_at(4, IDLE, 1); expect_at(3, DSW_M, 1); expect_at(4, DSW_M, 0);
    step(TO + 3);
    expect_at(0, ERRT, 0); expect_at(0, ERRP, 0);
    step(1);
    fire(E_LDS_P);
    expect_at(TO, ERRT, 0); expect_at(TO, IDLE, 0);
    expect_at(TO + 1, ERRT, 1); expect_at(TO + 1, IDLE, 1); expect_at(TO + 5, ERRT, 1);
    step(TO + 5);
    n_cmp++;
    if (err_timeout !== 1'b1) begin
      n_bad++;
      $display("FAIL err_timeout cyc=%0d actual=%b required=1", cyc, err_timeout);
    end
    pulse_clr();
    expect_at(0, ERRT, 0);
    ldtack = 1;
    step(6);
    fire(E_LDS_M);
    expect_at(0, LDS, 0);
    step(TO - 3);
    ldtack = 0;
    expect_at(3, LDT_M, 1); expect_at(3, IDLE, 0); expect_at(4, IDLE, 1);
    expect_at(4, ERRT, 0); expect_at(5, ERRT, 0); expect_at(8, ERRT, 0);
    step(9);
    fire(E_D_P);
    expect_at(0, DL, 1); expect_at(0, ERRP, 0);
    fire(E_D_P);
    expect_at(0, DL, 1); expect_at(0, ERRP, 1);
    n_cmp++;
    if (d !== 1'b1 || err_protocol !== 1'b1) begin
      n_bad++;
      $display("FAIL d/err_protocol cyc=%0d actual=%b/%b required=1/1", cyc, d, err_protocol);
    end
    pulse_clr();
    expect_at(0, ERRP, 0);
    fire(E_DT_P | E_DT_M);
    expect_at(0, DTK, 0); expect_at(0, ERRP, 1);
    ev = E_DT_M; err_clr = 1;
    step(1);
    ev = '0; err_clr = 0;
    expect_at(0, DTK, 0); expect_at(0, ERRP, 1);
    pulse_clr();
    expect_at(0, ERRP, 0);
    fire(E_D_M);
    expect_at(0, DL, 0); expect_at(0, ERRP, 0);
    fire(E_DT_P);
    expect_at(0, DTK, 1); expect_at(0, ERRP, 0);
    step(1);
    fire(E_LDS_P);
    expect_at(0, LDS, 1); expect_at(0, IDLE, 0);
    step(2);
    reset = 1;
    step(1);
    reset = 0;
    n_cmp++;
    if (lds !== 1'b0 || dut.state != WD_IDLE) begin
      n_bad++;
      $display("FAIL reset-abort cyc=%0d lds=%b state=%0d", cyc, lds, dut.state);
    end
    expect_at(0, LDS, 0); expect_at(0, IDLE, 1); expect_at(0, DTK, 0); expect_at(0, ERRT, 0);
    expect_at(TO + 3, ERRT, 0); expect_at(TO + 3, IDLE, 1);
    step(TO + 6);
    for (int i = 0; i < 10 && q.size() > 0; i++) step(1);
    foreach (q[i]) begin
      n_bad++;
      $display("FAIL %s cyc=%0d actual=unchecked required=%b", names[q[i].sig], q[i].cyc, q[i].val);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
